// File: rtl/countdown_timer_if.sv
// Control and digit bundle for countdown_timer: host drives strobes and preset,
// timer returns the six BCD digits plus status.
interface countdown_timer_if;
   logic        en;
   logic        load;
   logic        start;
   logic [23:0] cin;
   logic [3:0]  hour_t;
   logic [3:0]  hour_o;
   logic [3:0]  min_t;
   logic [3:0]  min_o;
   logic [3:0]  sec_t;
   logic [3:0]  sec_o;
   logic        running;
   logic        done;
   logic        err;

   modport master (
      output en, load, start, cin,
      input  hour_t, hour_o, min_t, min_o, sec_t, sec_o, running, done, err
   );

   modport slave (
      input  en, load, start, cin,
      output hour_t, hour_o, min_t, min_o, sec_t, sec_o, running, done, err
   );
endinterface

// File: rtl/countdown_timer.sv
// BCD hh:mm:ss countdown timer. Loads a validated preset, decrements once per
// TICK_DIV enabled cycles while running, and pulses done on reaching 00:00:00.
module countdown_timer #(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input logic              clk,
   input logic              rst,
   countdown_timer_if.slave bus
);

   localparam int unsigned PresW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [23:0]      digits_q, digits_d;
   logic [PresW-1:0] presc_q, presc_d;
   logic             err_q, err_d;
   logic             done_q, done_d;

   logic             load_ok;
   logic             tick;
   logic [23:0]      digits_dec;

   // Preset is legal only if every nibble fits its digit position.
   function automatic logic bcd_valid(input logic [23:0] v);
      return (v[23:20] <= 4'd9) && (v[19:16] <= 4'd9) && (v[15:12] <= 4'd5) &&
             (v[11:8] <= 4'd9) && (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
   endfunction

   // One-second decrement with borrow; callers guarantee a nonzero input.
   function automatic logic [23:0] dec_time(input logic [23:0] t);
      logic [23:0] r;
      logic [3:0]  nib;
      logic [3:0]  lim;
      logic        borrow;
      r      = t;
      borrow = 1'b1;
      for (int i = 0; i < 6; i++) begin
         nib = t[4*i +: 4];
         lim = (i == 1 || i == 3) ? 4'd5 : 4'd9;
         if (borrow) begin
            if (nib == 4'd0) begin
               nib = lim;
            end else begin
               nib    = nib - 4'd1;
               borrow = 1'b0;
            end
         end
         r[4*i +: 4] = nib;
      end
      return r;
   endfunction

   assign load_ok    = bcd_valid(bus.cin);
   assign tick       = bus.en && (presc_q == PresW'(TICK_DIV - 1));
   assign digits_dec = dec_time(digits_q);

   // Next-state: load has priority over start and aborts a running count.
   always_comb begin
      state_d  = state_q;
      digits_d = digits_q;
      presc_d  = presc_q;
      err_d    = err_q;
      done_d   = 1'b0;
      case (state_q)
         StRun: begin
            if (bus.load) begin
               state_d = StIdle;
               if (load_ok) begin
                  digits_d = bus.cin;
                  err_d    = 1'b0;
               end else begin
                  err_d = 1'b1;
               end
            end else if (tick) begin
               presc_d  = '0;
               digits_d = digits_dec;
               if (digits_dec == 24'h0) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end
            end else if (bus.en) begin
               presc_d = presc_q + PresW'(1);
            end
         end
         default: begin
            // Idle and done share load handling; only idle honours start.
            if (bus.load) begin
               if (load_ok) begin
                  digits_d = bus.cin;
                  err_d    = 1'b0;
                  state_d  = StIdle;
               end else begin
                  err_d = 1'b1;
               end
            end else if (bus.start && state_q == StIdle && digits_q != 24'h0) begin
               state_d = StRun;
               presc_d = '0;
            end
         end
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         digits_q <= '0;
         presc_q  <= '0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         digits_q <= digits_d;
         presc_q  <= presc_d;
         err_q    <= err_d;
         done_q   <= done_d;
      end
   end

   assign bus.hour_t  = digits_q[23:20];
   assign bus.hour_o  = digits_q[19:16];
   assign bus.min_t   = digits_q[15:12];
   assign bus.min_o   = digits_q[11:8];
   assign bus.sec_t   = digits_q[7:4];
   assign bus.sec_o   = digits_q[3:0];
   assign bus.running = (state_q == StRun);
   assign bus.done    = done_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer with TICK_DIV=4: stimulus queues the
// expected {digits, running, done, err} per cycle, a monitor pops and compares.
module tb_countdown_timer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   bit   finished = 1'b0;
   int   checks = 0;
   int   errors = 0;

   int          exp_cyc[$];
   string       exp_name[$];
   logic [26:0] exp_val[$];

   countdown_timer_if bus ();

   countdown_timer #(
      .TICK_DIV(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int c, input string nm, input logic [23:0] d, input logic r,
                       input logic dn, input logic e);
      exp_cyc.push_back(c);
      exp_name.push_back(nm);
      exp_val.push_back({d, r, dn, e});
   endtask

   task automatic step_n(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_load(input logic [23:0] v);
      bus.cin  = v;
      bus.load = 1'b1;
      step_n(1);
      bus.load = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      step_n(1);
      bus.start = 1'b0;
   endtask

   task automatic compare(input string nm, input logic [26:0] got, input logic [26:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got digits=%h run=%b done=%b err=%b, want digits=%h run=%b done=%b err=%b",
                  nm, got[26:3], got[2], got[1], got[0], want[26:3], want[2], want[1], want[0]);
      end
   endtask

   // Monitor: the only process that updates the check and error counts.
   initial begin : monitor
      logic [26:0] act;
      logic [26:0] want;
      string       nm;
      int          c;
      bit          seen;
      while (!finished) begin
         @(negedge clk or posedge rst);
         if (rst) begin
            #1;
            act = {bus.hour_t, bus.hour_o, bus.min_t, bus.min_o, bus.sec_t, bus.sec_o,
                   bus.running, bus.done, bus.err};
            compare("reset_state", act, 27'h0);
         end else begin
            act  = {bus.hour_t, bus.hour_o, bus.min_t, bus.min_o, bus.sec_t, bus.sec_o,
                    bus.running, bus.done, bus.err};
            seen = 1'b0;
            while (exp_cyc.size() > 0 && exp_cyc[0] <= cyc) begin
               c    = exp_cyc.pop_front();
               nm   = exp_name.pop_front();
               want = exp_val.pop_front();
               if (c < cyc) begin
                  checks++;
                  errors++;
                  $display("FAIL %s: expected at cycle %0d, never sampled (now %0d)", nm, c, cyc);
               end else begin
                  compare(nm, act, want);
                  seen = 1'b1;
               end
            end
            if (!seen) begin
               checks++;
               if (bus.done !== 1'b0) begin
                  errors++;
                  $display("FAIL spurious_done: got done=%b at cycle %0d, want 0", bus.done, cyc);
               end
            end
         end
      end
      while (exp_name.size() > 0) begin
         nm = exp_name.pop_front();
         c  = exp_cyc.pop_front();
         void'(exp_val.pop_front());
         checks++;
         errors++;
         $display("FAIL %s: expectation for cycle %0d left unchecked", nm, c);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int e0;
      bus.en    = 1'b0;
      bus.load  = 1'b0;
      bus.start = 1'b0;
      bus.cin   = 24'h0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      bus.en = 1'b1;

      // Basic three-second countdown.
      push(cyc + 1, "t1_load", 24'h000003, 1'b0, 1'b0, 1'b0);
      pulse_load(24'h000003);
      e0 = cyc + 1;
      push(e0,      "t1_running",    24'h000003, 1'b1, 1'b0, 1'b0);
      push(e0 + 3,  "t1_hold",       24'h000003, 1'b1, 1'b0, 1'b0);
      push(e0 + 4,  "t1_dec1",       24'h000002, 1'b1, 1'b0, 1'b0);
      push(e0 + 8,  "t1_dec2",       24'h000001, 1'b1, 1'b0, 1'b0);
      push(e0 + 12, "t1_zero_done",  24'h000000, 1'b0, 1'b1, 1'b0);
      push(e0 + 13, "t1_done_clear", 24'h000000, 1'b0, 1'b0, 1'b0);
      pulse_start();
      step_n(13);

      // Start in DONE is ignored.
      push(cyc + 1, "done_start_ignored", 24'h000000, 1'b0, 1'b0, 1'b0);
      pulse_start();

      // Full borrow chain from 10:00:00.
      push(cyc + 1, "t2_load", 24'h100000, 1'b0, 1'b0, 1'b0);
      pulse_load(24'h100000);
      e0 = cyc + 1;
      push(e0 + 4, "t2_borrow", 24'h095959, 1'b1, 1'b0, 1'b0);
      pulse_start();
      step_n(4);

      // Load and start together in RUN: load wins and aborts.
      push(cyc + 1, "t5_load_wins", 24'h000500, 1'b0, 1'b0, 1'b0);
      bus.cin   = 24'h000500;
      bus.load  = 1'b1;
      bus.start = 1'b1;
      step_n(1);
      bus.load  = 1'b0;
      bus.start = 1'b0;

      // Start with all-zero digits stays idle.
      push(cyc + 1, "t5_load_zero", 24'h000000, 1'b0, 1'b0, 1'b0);
      pulse_load(24'h000000);
      e0 = cyc + 1;
      push(e0,     "t5_start_zero",      24'h000000, 1'b0, 1'b0, 1'b0);
      push(e0 + 5, "t5_start_zero_late", 24'h000000, 1'b0, 1'b0, 1'b0);
      pulse_start();
      step_n(5);

      // Preset validation.
      push(cyc + 1, "t3_bad_sec", 24'h000000, 1'b0, 1'b0, 1'b1);
      pulse_load(24'h000060);
      push(cyc + 1, "t3_bad_min", 24'h000000, 1'b0, 1'b0, 1'b1);
      pulse_load(24'h006000);
      push(cyc + 1, "t3_good", 24'h000059, 1'b0, 1'b0, 1'b0);
      pulse_load(24'h000059);

      // Pause: 10 disabled cycles stretch the first second.
      push(cyc + 1, "t4_load", 24'h000002, 1'b0, 1'b0, 1'b0);
      pulse_load(24'h000002);
      e0 = cyc + 1;
      push(e0 + 8,  "t4_paused",     24'h000002, 1'b1, 1'b0, 1'b0);
      push(e0 + 13, "t4_hold",       24'h000002, 1'b1, 1'b0, 1'b0);
      push(e0 + 14, "t4_dec1",       24'h000001, 1'b1, 1'b0, 1'b0);
      push(e0 + 17, "t4_hold2",      24'h000001, 1'b1, 1'b0, 1'b0);
      push(e0 + 18, "t4_zero_done",  24'h000000, 1'b0, 1'b1, 1'b0);
      push(e0 + 19, "t4_done_clear", 24'h000000, 1'b0, 1'b0, 1'b0);
      pulse_start();
      step_n(2);
      bus.en = 1'b0;
      step_n(10);
      bus.en = 1'b1;
      step_n(7);

      // Sticky err, then asynchronous reset mid-count.
      push(cyc + 1, "t6_load", 24'h000030, 1'b0, 1'b0, 1'b0);
      pulse_load(24'h000030);
      push(cyc + 1, "t6_bad_load", 24'h000030, 1'b0, 1'b0, 1'b1);
      pulse_load(24'h0000f0);
      push(cyc + 1, "t6_running_err", 24'h000030, 1'b1, 1'b0, 1'b1);
      pulse_start();
      step_n(6);
      #2 rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      step_n(2);
      push(cyc + 1, "t6_after_reset", 24'h000001, 1'b0, 1'b0, 1'b0);
      pulse_load(24'h000001);
      step_n(2);
      finished = 1'b1;
   end

endmodule
